// File: rtl/clk_meter_pkg.sv
//------------------------------------------------------------------------------
// Module   : clk_meter_pkg
// Brief    : Shared types and constants for the clk_meter clock monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_e;

  localparam int DUTY_W    = 7;
  localparam int PCT_SCALE = 100;

endpackage

`default_nettype wire

// File: rtl/clk_meter_div.sv
//------------------------------------------------------------------------------
// Module   : clk_meter_div
// Brief    : Unsigned sequential restoring divider, one quotient bit per cycle;
//            the first bit is resolved on the start cycle itself.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_meter_div #(
  parameter int DVD_W = 23,
  parameter int DVS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q, rem_d, dvs_q, dvs_d, rem_src, dvs_src;
  logic [DVD_W-1:0] work_q, work_d, work_src, quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             ge, last;
  logic [DVS_W:0]   trial, diff;

  // work_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    rem_src  = start ? '0 : rem_q;
    work_src = start ? dividend : work_q;
    dvs_src  = start ? divisor : dvs_q;
    trial    = {rem_src, work_src[DVD_W-1]};
    diff     = trial - {1'b0, dvs_src};
    ge       = (trial >= {1'b0, dvs_src});
    last     = !start && busy_q && (cnt_q == CW'(1));

    rem_d  = rem_q;
    work_d = work_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    if (start || busy_q) begin
      rem_d  = ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
      work_d = {work_src[DVD_W-2:0], ge};
      dvs_d  = dvs_src;
      cnt_d  = start ? CW'(DVD_W - 1) : cnt_q - CW'(1);
    end
    busy_d = start || (busy_q && !last);
    done_d = last;
    quo_d  = last ? work_d : quo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      work_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      work_q <= work_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign quotient = quo_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: rtl/clk_meter.sv
//------------------------------------------------------------------------------
// Module   : clk_meter
// Brief    : Measures period/high time of meas_clk in clk cycles, flags a stuck
//            clock; duty-cycle percentage enabled by macro CLK_METER_DUTY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              meas_clk,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic              meas_valid,
  output logic              stuck,
  output logic              stuck_level,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              duty_valid
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic [CNT_W-1:0]       acc_q, acc_d, high_acc_q, high_acc_d;
  logic [CNT_W-1:0]       period_q, period_d, high_q, high_d;
  logic                   valid_q, valid_d, stuck_q, stuck_d, level_q, level_d;
  logic                   s, rise, fall, timeout, publish, go_stuck;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign timeout = (acc_q == TIMEOUT_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      s_d_q      <= 1'b0;
      acc_q      <= '0;
      high_acc_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      s_d_q      <= s_d_d;
      acc_q      <= acc_d;
      high_acc_q <= high_acc_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
      level_q    <= level_d;
    end
  end

  // edges take priority over the timeout in every state
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = HIGH; else if (timeout) state_d = STUCK;
        HIGH:    if (fall) state_d = LOW;
                 else if (rise) state_d = HIGH;
                 else if (timeout) state_d = STUCK;
        LOW:     if (rise) state_d = HIGH; else if (timeout) state_d = STUCK;
        STUCK:   if (rise) state_d = HIGH; else if (fall && level_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], meas_clk};
    s_d_d    = s;
    publish  = en && rise && ((state_q == LOW) || (state_q == HIGH));
    go_stuck = en && (state_d == STUCK) && (state_q != STUCK);

    // acc parks in STUCK so it cannot wrap while the clock is dead
    if (!en || (state_q == STUCK && state_d == IDLE)) acc_d = '0;
    else if (rise)                                   acc_d = CNT_W'(1);
    else if (state_q == STUCK)                       acc_d = acc_q;
    else                                             acc_d = acc_q + CNT_W'(1);

    high_acc_d = (en && fall && state_q == HIGH) ? acc_q : high_acc_q;
    period_d   = publish ? acc_q : period_q;
    high_d     = publish ? high_acc_q : high_q;
    valid_d    = publish;
    stuck_d    = en && (state_d == STUCK);
    level_d    = go_stuck ? s : level_q;
  end

  assign period_cnt  = period_q;
  assign high_cnt    = high_q;
  assign meas_valid  = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = level_q;

`ifdef CLK_METER_DUTY_EN
  localparam int DIV_W = CNT_W + DUTY_W;

  logic [DIV_W-1:0] dividend, quo;
  logic             div_busy, div_done;

  assign dividend = DIV_W'(high_q) * DIV_W'(PCT_SCALE);

  clk_meter_div #(
    .DVD_W (DIV_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (valid_q),
    .dividend (dividend),
    .divisor  (period_q),
    .busy     (div_busy),
    .quotient (quo),
    .done     (div_done)
  );

  // high never exceeds period, so the upper bits only guard against bad input
  assign duty_pct   = (|quo[DIV_W-1:DUTY_W]) ? DUTY_W'(PCT_SCALE) : quo[DUTY_W-1:0];
  assign duty_valid = div_done && !div_busy;
`else
  assign duty_pct   = '0;
  assign duty_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_meter.sv
//------------------------------------------------------------------------------
// Module   : tb_clk_meter
// Brief    : Scoreboard bench for clk_meter; duty checks under CLK_METER_DUTY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;
  localparam int DIV_LAT = CNT_W + 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b1;
  logic             meas_clk = 1'b0;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             meas_valid, stuck, stuck_level, duty_valid;
  logic [6:0]       duty_pct;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [31:0] sb[$];
  bit          dv_pend = 1'b0;
  int          dv_due  = 0;
  int          dv_val  = 0;

  clk_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .meas_clk    (meas_clk),
    .period_cnt  (period_cnt),
    .high_cnt    (high_cnt),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level),
    .duty_pct    (duty_pct),
    .duty_valid  (duty_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input int h);
    sb.push_back({16'(p), 16'(h)});
  endtask

  // n periods of p cycles with h high; each rise after the first publishes (p,h)
  task automatic gen(input int p, input int h, input int n, input bit skip_first, input int ofs);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #(ofs); meas_clk = 1'b1;
      if (!(skip_first && i == 0)) push(p, h);
      repeat (h) @(posedge clk);
      #(ofs); meas_clk = 1'b0;
      repeat (p - h - 1) @(posedge clk);
    end
  endtask

  task automatic gap();
    meas_clk = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("gap_stuck", 32'(stuck), 32'd1);
    chk("gap_level", 32'(stuck_level), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (rst) dv_pend = 1'b0;
`ifdef CLK_METER_DUTY_EN
    if (duty_valid) begin
      if (!dv_pend) chk("duty_unexp", 32'd1, 32'd0);
      else begin
        chk("duty_lat", 32'(cyc), 32'(dv_due));
        chk("duty_pct", 32'(duty_pct), 32'(dv_val));
        dv_pend = 1'b0;
      end
    end else if (dv_pend && cyc > dv_due) begin
      chk("duty_late", 32'd0, 32'd1);
      dv_pend = 1'b0;
    end
`else
    if (duty_valid) chk("duty_unexp", 32'd1, 32'd0);
`endif
    if (meas_valid) begin
      if (sb.size() == 0) chk("valid_unexp", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("period", 32'(period_cnt), 32'(e[31:16]));
        chk("high", 32'(high_cnt), 32'(e[15:0]));
        dv_pend = 1'b1;
        dv_due  = cyc + DIV_LAT;
        dv_val  = (int'(e[15:0]) * 100) / int'(e[31:16]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    // reset values
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(period_cnt), 32'd0);
    chk("rst_high", 32'(high_cnt), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_stuck", 32'(stuck), 32'd0);
    chk("rst_level", 32'(stuck_level), 32'd0);
    chk("rst_duty", 32'(duty_pct), 32'd0);
    chk("rst_dvalid", 32'(duty_valid), 32'd0);
    #1 rst = 1'b0;

    // stuck low from reset: acc reaches TIMEOUT after 20 edges, stuck one edge later
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    chk("idle_stuck_early", 32'(stuck), 32'd0);
    @(negedge clk);
    chk("idle_stuck", 32'(stuck), 32'd1);
    chk("idle_level", 32'(stuck_level), 32'd0);

    // basic 10/5, first rise clears stuck
    gen(10, 5, 5, 1'b1, 2);
    chk("basic_unstuck", 32'(stuck), 32'd0);

    // stuck high: rise publishes, then 22 edges until acc hits TIMEOUT
    @(posedge clk); #2; meas_clk = 1'b1;
    push(10, 5);
    repeat (TIMEOUT + 2) @(posedge clk);
    @(negedge clk);
    chk("high_stuck_early", 32'(stuck), 32'd0);
    @(negedge clk);
    chk("high_stuck", 32'(stuck), 32'd1);
    chk("high_level", 32'(stuck_level), 32'd1);
    chk("hold_period", 32'(period_cnt), 32'd10);
    chk("hold_high", 32'(high_cnt), 32'd5);
    meas_clk = 1'b0;
    repeat (6) @(negedge clk);
    chk("fall_unstuck", 32'(stuck), 32'd0);
    gen(8, 4, 4, 1'b1, 2);
    gap();

    // asymmetric duty
    gen(7, 2, 4, 1'b1, 3);
    gap();

    // en dropped mid high phase
    gen(10, 5, 3, 1'b1, 4);
    @(posedge clk); #4; meas_clk = 1'b1;
    push(10, 5);
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk); #4; meas_clk = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("en_period", 32'(period_cnt), 32'd10);
    chk("en_high", 32'(high_cnt), 32'd5);
    chk("en_stuck", 32'(stuck), 32'd0);
    @(posedge clk); #1 en = 1'b1;
    repeat (3) @(posedge clk);
    gen(10, 5, 3, 1'b1, 4);
    gap();

    // minimum pulses with a random phase offset
    gen(4, 2, 100, 1'b1, int'($urandom_range(1, 9)));
    gap();

    // reset mid-measurement with the divider busy
    gen(10, 5, 2, 1'b1, 3);
    @(posedge clk); #3; meas_clk = 1'b1;
    push(10, 5);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = meas_valid;
    end
    chk("mv_wait", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_period", 32'(period_cnt), 32'd0);
    chk("mid_rst_high", 32'(high_cnt), 32'd0);
    chk("mid_rst_duty", 32'(duty_pct), 32'd0);
    chk("mid_rst_stuck", 32'(stuck), 32'd0);
    meas_clk = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);

    chk("sb_left", 32'(sb.size()), 32'd0);
    chk("duty_left", 32'(dv_pend), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
